seq_detector_param: RTL and testbench

Parametrised serial bit-pattern detector: the next generation of the fixed 4-bit "1010" Mealy detector. Pattern width is a parameter. The pattern and overlap mode are runtime-loadable. An input-valid qualifier gates every bit, and the block keeps a saturating match counter. It sits on a serial bit stream between a deserialiser/sampler and a control block that consumes match pulses and counts.

---
 rtl/seq_det_pkg.sv | 13 +
 rtl/seq_detector_param_if.sv | 29 ++
 rtl/seq_det_history.sv | 55 +++++
 rtl/seq_detector_param.sv | 90 +++++++++
 tb/tb_seq_detector_param.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
// Imported by the history sub-module and the detector top level.
package seq_det_pkg;

  localparam int         PATTERN_W_MAX   = 32;
  localparam logic [3:0] DEFAULT_PATTERN = 4'b1010;

  // Fill counts 0..PATTERN_W-1, so $clog2(PATTERN_W) bits suffice.
  function automatic int fill_width(input int pattern_w);
    return (pattern_w < 2) ? 1 : $clog2(pattern_w);
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Bit-stream, configuration and match-report bundle of the pattern detector.
// The detector sits on the slave side; stream source and consumer use master.
interface seq_detector_param_if #(
  parameter int PATTERN_W = 4,
  parameter int CNT_W     = 8
);

  logic                 in_valid;
  logic                 in_bit;
  logic                 cfg_load;
  logic [PATTERN_W-1:0] cfg_pattern;
  logic                 cfg_overlap;
  logic                 count_clear;
  logic                 match;
  logic                 match_q;
  logic [CNT_W-1:0]     match_count;
  logic [PATTERN_W-1:0] pattern;

  modport master (
    output in_valid, in_bit, cfg_load, cfg_pattern, cfg_overlap, count_clear,
    input  match, match_q, match_count, pattern
  );

  modport slave (
    input  in_valid, in_bit, cfg_load, cfg_pattern, cfg_overlap, count_clear,
    output match, match_q, match_count, pattern
  );

endinterface

// File: rtl/seq_det_history.sv
// Bit history shift register with a saturating count of valid bits held.
// flush empties everything; clear restarts the count while the shift still happens.
module seq_det_history
  import seq_det_pkg::*;
#(
  parameter int PATTERN_W = 4,
  parameter int FILL_W    = fill_width(PATTERN_W)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 shift_i,
  input  logic                 bit_i,
  input  logic                 flush_i,
  input  logic                 clear_i,
  output logic [PATTERN_W-2:0] hist_o,
  output logic [FILL_W-1:0]    fill_o
);

  localparam int                HIST_W    = PATTERN_W - 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W - 1);

  logic [HIST_W-1:0] hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (flush_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_i) begin
      // Oldest bit falls off the top; only the newest PATTERN_W-1 are kept.
      hist_d = HIST_W'({hist_q, bit_i});
      if (clear_i) begin
        fill_d = '0;
      end else if (fill_q != FILL_FULL) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign hist_o = hist_q;
  assign fill_o = fill_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with runtime pattern/overlap config and a saturating match counter.
// match is combinational on the final bit; match_q follows one cycle later.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                   PATTERN_W     = 4,
  parameter logic [PATTERN_W-1:0] RESET_PATTERN = PATTERN_W'(DEFAULT_PATTERN),
  parameter logic                 RESET_OVERLAP = 1'b1,
  parameter int                   CNT_W         = 8
) (
  input logic                 clk,
  input logic                 reset,
  seq_detector_param_if.slave bus
);

  localparam int                FILL_W    = fill_width(PATTERN_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W - 1);

  if (PATTERN_W < 2 || PATTERN_W > PATTERN_W_MAX) begin : g_bad_width
    $error("seq_detector_param: PATTERN_W out of range 2..32");
  end

  logic [PATTERN_W-1:0] pattern_q, pattern_d;
  logic                 overlap_q, overlap_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 match_dly_q, match_dly_d;

  logic [PATTERN_W-2:0] hist;
  logic [FILL_W-1:0]    fill;
  logic                 accept;
  logic                 match;

  // A bit presented alongside cfg_load is dropped, never shifted in.
  assign accept = bus.in_valid & ~bus.cfg_load;
  assign match  = accept & (fill == FILL_FULL) & ({hist, bus.in_bit} == pattern_q);

  seq_det_history #(
    .PATTERN_W (PATTERN_W),
    .FILL_W    (FILL_W)
  ) u_history (
    .clk     (clk),
    .reset   (reset),
    .shift_i (accept),
    .bit_i   (bus.in_bit),
    .flush_i (bus.cfg_load),
    .clear_i (match & ~overlap_q),
    .hist_o  (hist),
    .fill_o  (fill)
  );

  always_comb begin
    pattern_d = pattern_q;
    overlap_d = overlap_q;
    if (bus.cfg_load) begin
      pattern_d = bus.cfg_pattern;
      overlap_d = bus.cfg_overlap;
    end
  end

  always_comb begin
    count_d = count_q;
    if (bus.count_clear) begin
      count_d = '0;
    end else if (match && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  assign match_dly_d = match;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_q   <= RESET_PATTERN;
      overlap_q   <= RESET_OVERLAP;
      count_q     <= '0;
      match_dly_q <= 1'b0;
    end else begin
      pattern_q   <= pattern_d;
      overlap_q   <= overlap_d;
      count_q     <= count_d;
      match_dly_q <= match_dly_d;
    end
  end

  assign bus.match       = match;
  assign bus.match_q     = match_dly_q;
  assign bus.match_count = count_q;
  assign bus.pattern     = pattern_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench: vector table on a default 1010 detector, then reset and
// counter-saturation sequences on a CNT_W=2 detector loaded with 1111.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seq_detector_param_if #(.PATTERN_W(4), .CNT_W(8)) bus_a ();
  seq_detector_param_if #(.PATTERN_W(4), .CNT_W(2)) bus_b ();

  seq_detector_param #(
    .PATTERN_W(4), .RESET_PATTERN(4'b1010), .RESET_OVERLAP(1'b1), .CNT_W(8)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  seq_detector_param #(
    .PATTERN_W(4), .RESET_PATTERN(4'b1111), .RESET_OVERLAP(1'b1), .CNT_W(2)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  typedef struct {
    logic       vld, b, ld;
    logic [3:0] pat;
    logic       ovl, clr;
    logic       m, mq;
    logic [7:0] cnt;
    logic [3:0] pe;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic vld, b, ld, input logic [3:0] pat, input logic ovl, clr,
                     input logic m, mq, input logic [7:0] cnt, input logic [3:0] pe);
    vec_t v;
    v.vld = vld; v.b = b; v.ld = ld; v.pat = pat; v.ovl = ovl; v.clr = clr;
    v.m = m; v.mq = mq; v.cnt = cnt; v.pe = pe;
    vecs.push_back(v);
  endtask

  task automatic drive_a(input logic vld, b, clr);
    @(negedge clk);
    bus_a.in_valid = vld; bus_a.in_bit = b; bus_a.count_clear = clr;
    bus_a.cfg_load = 1'b0;
    #2;
  endtask

  initial begin
    reset = 1'b1;
    bus_a.in_valid = 0; bus_a.in_bit = 0; bus_a.cfg_load = 0;
    bus_a.cfg_pattern = 4'h0; bus_a.cfg_overlap = 0; bus_a.count_clear = 0;
    bus_b.in_valid = 0; bus_b.in_bit = 0; bus_b.cfg_load = 0;
    bus_b.cfg_pattern = 4'h0; bus_b.cfg_overlap = 0; bus_b.count_clear = 0;

    // vld b ld pat ovl clr | match match_q count(pre-edge) pattern(pre-edge)
    // default config, overlap: 1,0,1,0,1,0
    add(1,1,0,4'h0,0,0, 0,0,0,4'hA); add(1,0,0,4'h0,0,0, 0,0,0,4'hA);
    add(1,1,0,4'h0,0,0, 0,0,0,4'hA); add(1,0,0,4'h0,0,0, 1,0,0,4'hA);
    add(1,1,0,4'h0,0,0, 0,1,1,4'hA); add(1,0,0,4'h0,0,0, 1,0,1,4'hA);
    // load 1010 non-overlap, then 1,0,1,0,1,0,1,0
    add(0,0,1,4'hA,0,0, 0,1,2,4'hA);
    add(1,1,0,4'h0,0,0, 0,0,2,4'hA); add(1,0,0,4'h0,0,0, 0,0,2,4'hA);
    add(1,1,0,4'h0,0,0, 0,0,2,4'hA); add(1,0,0,4'h0,0,0, 1,0,2,4'hA);
    add(1,1,0,4'h0,0,0, 0,1,3,4'hA); add(1,0,0,4'h0,0,0, 0,0,3,4'hA);
    add(1,1,0,4'h0,0,0, 0,0,3,4'hA); add(1,0,0,4'h0,0,0, 1,0,3,4'hA);
    // 1,0,1,0 with idle cycles carrying junk bits in between
    add(0,0,0,4'h0,0,0, 0,1,4,4'hA); add(1,1,0,4'h0,0,0, 0,0,4,4'hA);
    add(0,1,0,4'h0,0,0, 0,0,4,4'hA); add(1,0,0,4'h0,0,0, 0,0,4,4'hA);
    add(0,0,0,4'h0,0,0, 0,0,4,4'hA); add(1,1,0,4'h0,0,0, 0,0,4,4'hA);
    add(0,0,0,4'h0,0,0, 0,0,4,4'hA); add(1,0,0,4'h0,0,0, 1,0,4,4'hA);
    add(0,0,0,4'h0,0,0, 0,1,5,4'hA);
    // cfg_load on the 4th bit discards it; 1,0,1,0 then matches
    add(1,1,0,4'h0,0,0, 0,0,5,4'hA); add(1,0,0,4'h0,0,0, 0,0,5,4'hA);
    add(1,1,0,4'h0,0,0, 0,0,5,4'hA); add(1,0,1,4'hA,1,0, 0,0,5,4'hA);
    add(1,1,0,4'h0,0,0, 0,0,5,4'hA); add(1,0,0,4'h0,0,0, 0,0,5,4'hA);
    add(1,1,0,4'h0,0,0, 0,0,5,4'hA); add(1,0,0,4'h0,0,0, 1,0,5,4'hA);
    add(0,0,0,4'h0,0,0, 0,1,6,4'hA);
    // new pattern 0110 takes effect the cycle after the load
    add(1,1,1,4'h6,1,0, 0,0,6,4'hA); add(1,0,0,4'h0,0,0, 0,0,6,4'h6);
    add(1,1,0,4'h0,0,0, 0,0,6,4'h6); add(1,1,0,4'h0,0,0, 0,0,6,4'h6);
    add(1,0,0,4'h0,0,0, 1,0,6,4'h6);
    // clear coincident with a match wins
    add(1,0,0,4'h0,0,0, 0,1,7,4'h6); add(1,1,0,4'h0,0,0, 0,0,7,4'h6);
    add(1,1,0,4'h0,0,0, 0,0,7,4'h6); add(1,0,0,4'h0,0,1, 1,0,7,4'h6);
    add(0,0,0,4'h0,0,0, 0,1,0,4'h6);
    add(0,0,1,4'hA,1,0, 0,0,0,4'h6);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    chk("rst_a match",   bus_a.match,       1'b0);
    chk("rst_a match_q", bus_a.match_q,     1'b0);
    chk("rst_a count",   bus_a.match_count, 8'd0);
    chk("rst_a pattern", bus_a.pattern,     4'hA);
    chk("rst_b pattern", bus_b.pattern,     4'hF);
    chk("rst_b count",   bus_b.match_count, 2'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      bus_a.in_valid = vecs[i].vld; bus_a.in_bit = vecs[i].b;
      bus_a.cfg_load = vecs[i].ld; bus_a.cfg_pattern = vecs[i].pat;
      bus_a.cfg_overlap = vecs[i].ovl; bus_a.count_clear = vecs[i].clr;
      #2;
      chk($sformatf("row%0d match", i),   bus_a.match,       vecs[i].m);
      chk($sformatf("row%0d match_q", i), bus_a.match_q,     vecs[i].mq);
      chk($sformatf("row%0d count", i),   bus_a.match_count, vecs[i].cnt);
      chk($sformatf("row%0d pattern", i), bus_a.pattern,     vecs[i].pe);
    end

    // Reset mid-stream: history ending 1,0,1 must not complete with a 0.
    drive_a(1, 1, 0); drive_a(1, 0, 0); drive_a(1, 1, 0); drive_a(1, 0, 0);
    chk("pre_rst match", bus_a.match, 1'b1);
    drive_a(1, 1, 0);
    chk("pre_rst no match", bus_a.match, 1'b0);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    reset = 1'b1;
    #2;
    chk("mid_rst count",   bus_a.match_count, 8'd0);
    chk("mid_rst match_q", bus_a.match_q,     1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive_a(1, 0, 0);
    chk("post_rst 0", bus_a.match, 1'b0);
    drive_a(1, 1, 0); chk("post_rst b1", bus_a.match, 1'b0);
    drive_a(1, 0, 0); chk("post_rst b2", bus_a.match, 1'b0);
    drive_a(1, 1, 0); chk("post_rst b3", bus_a.match, 1'b0);
    drive_a(1, 0, 0); chk("post_rst b4", bus_a.match, 1'b1);
    drive_a(0, 0, 0);
    chk("post_rst count", bus_a.match_count, 8'd1);

    // Saturating 2-bit counter on pattern 1111, overlapping.
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus_b.in_valid = 1'b1; bus_b.in_bit = 1'b1;
      #2;
      chk($sformatf("sat bit%0d match", k),   bus_b.match,       (k >= 4) ? 1'b1 : 1'b0);
      chk($sformatf("sat bit%0d match_q", k), bus_b.match_q,     (k >= 5) ? 1'b1 : 1'b0);
      chk($sformatf("sat bit%0d count", k),   bus_b.match_count, (k <= 4) ? 0 : ((k - 4 > 3) ? 3 : k - 4));
    end
    @(negedge clk);
    bus_b.count_clear = 1'b1;
    #2;
    chk("clr_match match", bus_b.match,       1'b1);
    chk("clr_match count", bus_b.match_count, 2'd3);
    @(negedge clk);
    bus_b.in_valid = 1'b0; bus_b.count_clear = 1'b0;
    #2;
    chk("clr_after count",   bus_b.match_count, 2'd0);
    chk("clr_after match_q", bus_b.match_q,     1'b1);
    chk("clr_after match",   bus_b.match,       1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
